spi_master_ctrl: RTL and testbench

SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

---
 rtl/spi_pkg.sv | 17 +
 rtl/spi_clk_gen.sv | 46 ++++
 rtl/spi_master_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types for the SPI master: controller state encoding and the
// {cpol,cpha} mode constants.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK timebase: divides clk into half-periods and flags which half-period
// boundaries are leading or trailing SCLK edges.
module spi_clk_gen import spi_pkg::*; #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic edge_en,
  output logic half_tick,
  output logic lead,
  output logic trail
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase;

  // Counter and edge phase restart whenever the controller is idle, so every
  // transfer begins on a fresh half-period boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else begin
      if (half_tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (half_tick && edge_en) begin
        phase <= ~phase;
      end
    end
  end

  assign half_tick = run && (cnt == CNT_MAX);
  assign lead      = half_tick && edge_en && !phase;
  assign trail     = half_tick && edge_en && phase;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master controller: one frame per start pulse, modes 0-3, one-hot
// active-low chip selects. Optional LSB-first frames under SPI_MASTER_LSB_FIRST_EN.
module spi_master_ctrl import spi_pkg::*; #(
  parameter  int DATA_W  = 8,
  parameter  int CLK_DIV = 4,
  parameter  int NUM_CS  = 1,
  localparam int CSW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  input  logic [CSW-1:0]    cs_sel,
  input  logic              cpol,
  input  logic              cpha,
`ifdef SPI_MASTER_LSB_FIRST_EN
  input  logic              lsb_first,
`endif
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rx_data,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n
);

  localparam int HC_W = $clog2(2 * DATA_W);
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(2 * DATA_W - 1);

  spi_state_t state, state_next;

  logic              accept;
  logic              finish;
  logic              run;
  logic              edge_en;
  logic              half_tick;
  logic              lead;
  logic              trail;
  logic              shift_en;
  logic              sample_en;
  logic              cpha_q;
  logic [HC_W-1:0]   half_cnt;
  logic [DATA_W-1:0] tx_shift;
  logic [DATA_W-1:0] rx_shift;
  logic [DATA_W-1:0] frame_in;
  logic [DATA_W-1:0] rx_frame;
  logic [NUM_CS-1:0] cs_dec;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .run       (run),
    .edge_en   (edge_en),
    .half_tick (half_tick),
    .lead      (lead),
    .trail     (trail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (half_tick) begin
          state_next = XFER;
        end
      end
      XFER: begin
        if (half_tick && (half_cnt == HC_LAST)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (half_tick) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // The last XFER half-period sits at the idle level, so it carries no edge.
  assign run       = (state != IDLE);
  assign busy      = run;
  assign edge_en   = (state == SETUP) || ((state == XFER) && (half_cnt != HC_LAST));
  assign shift_en  = cpha_q ? lead : trail;
  assign sample_en = cpha_q ? trail : lead;

  always_comb begin
    cs_dec = '1;
    for (int i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CSW'(i)) begin
        cs_dec[i] = 1'b0;
      end
    end
  end

`ifdef SPI_MASTER_LSB_FIRST_EN
  logic              lsb_q;
  logic [DATA_W-1:0] tx_rev;
  logic [DATA_W-1:0] rx_rev;

  always_comb begin
    tx_rev = '0;
    rx_rev = '0;
    for (int i = 0; i < DATA_W; i++) begin
      tx_rev[i] = tx_data[DATA_W-1-i];
      rx_rev[i] = rx_shift[DATA_W-1-i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lsb_q <= 1'b0;
    end else if (accept) begin
      lsb_q <= lsb_first;
    end
  end

  // LSB-first reuses the MSB-first shifters on bit-reversed frames.
  assign frame_in = lsb_first ? tx_rev : tx_data;
  assign rx_frame = lsb_q ? rx_rev : rx_shift;
`else
  assign frame_in = tx_data;
  assign rx_frame = rx_shift;
`endif

  // With cpha=0 the first bit is presented at accept, so the shifter is
  // preloaded one position ahead.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done     <= 1'b0;
      rx_data  <= '0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      cpha_q   <= 1'b0;
      half_cnt <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        cpha_q   <= cpha;
        cs_n     <= cs_dec;
        sclk     <= cpol;
        half_cnt <= '0;
        rx_shift <= '0;
        if (cpha) begin
          tx_shift <= frame_in;
          mosi     <= 1'b0;
        end else begin
          tx_shift <= {frame_in[DATA_W-2:0], 1'b0};
          mosi     <= frame_in[DATA_W-1];
        end
      end else begin
        if (lead || trail) begin
          sclk <= ~sclk;
        end
        if (shift_en) begin
          mosi     <= tx_shift[DATA_W-1];
          tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};
        end
        if (sample_en) begin
          rx_shift <= {rx_shift[DATA_W-2:0], miso};
        end
        if ((state == XFER) && half_tick) begin
          half_cnt <= half_cnt + 1'b1;
        end
        if (finish) begin
          cs_n    <= '1;
          mosi    <= 1'b0;
          rx_data <= rx_frame;
        end
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboard bench for spi_master_ctrl: loopback and slave-model frames in all
// modes, chip-select decode, back-to-back starts and mid-transfer reset.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  localparam int DATA_W  = 8;
  localparam int CLK_DIV = 4;
  localparam int NUM_CS  = 5;
  localparam int CSW     = 3;
  localparam int LATENCY = 1 + (2 * DATA_W + 2) * CLK_DIV;
  localparam logic [NUM_CS-1:0] CS_IDLE = '1;

  typedef struct {
    logic [DATA_W-1:0] rx;
    logic [NUM_CS-1:0] cs;
    logic              pol;
    logic              first_mosi;
    int                start_cyc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [DATA_W-1:0] tx_data = '0;
  logic [CSW-1:0]    cs_sel = '0;
  logic              cpol = 1'b0;
  logic              cpha = 1'b0;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] rx_data;
  logic              sclk;
  logic              mosi;
  logic              miso;
  logic [NUM_CS-1:0] cs_n;
`ifdef SPI_MASTER_LSB_FIRST_EN
  logic              lsb_first = 1'b0;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int rises = 0;
  int done_seen = 0;

  exp_t sb[$];
  exp_t mon_e;

  logic              loop = 1'b1;
  logic              sl_bit = 1'b0;
  logic              sl_pol = 1'b0;
  logic              sl_pha = 1'b0;
  logic [DATA_W-1:0] sl_data = '0;
  int                sl_idx = 0;

  logic              prev_busy = 1'b0;
  logic              prev_sclk = 1'b0;
  logic              prev_done = 1'b0;
  logic [NUM_CS-1:0] prev_cs_n = '1;

  assign miso = loop ? mosi : sl_bit;

  spi_master_ctrl #(
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV),
    .NUM_CS  (NUM_CS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .tx_data   (tx_data),
    .cs_sel    (cs_sel),
    .cpol      (cpol),
    .cpha      (cpha),
`ifdef SPI_MASTER_LSB_FIRST_EN
    .lsb_first (lsb_first),
`endif
    .busy      (busy),
    .done      (done),
    .rx_data   (rx_data),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .cs_n      (cs_n)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [DATA_W-1:0] tx, input logic [CSW-1:0] sel,
                               input logic [1:0] mode, input logic lsb, input logic lp,
                               input logic [DATA_W-1:0] slave_byte);
    exp_t e;
    logic [NUM_CS-1:0] cs_exp;
    cs_exp = '1;
    if (int'(sel) < NUM_CS) cs_exp[sel] = 1'b0;
    e.rx         = lp ? tx : slave_byte;
    e.cs         = cs_exp;
    e.pol        = mode[1];
    e.first_mosi = mode[0] ? 1'b0 : (lsb ? tx[0] : tx[DATA_W-1]);
    e.start_cyc  = cyc;
    sb.push_back(e);
    loop    = lp;
    sl_data = slave_byte;
    sl_pol  = mode[1];
    sl_pha  = mode[0];
    sl_idx  = DATA_W - 1;
    sl_bit  = mode[0] ? 1'b0 : slave_byte[DATA_W-1];
    tx_data = tx;
    cs_sel  = sel;
    cpol    = mode[1];
    cpha    = mode[0];
`ifdef SPI_MASTER_LSB_FIRST_EN
    lsb_first = lsb;
`endif
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Start pulse that the DUT must ignore; deliberately pushes no expectation.
  task automatic pulseStart(input logic [DATA_W-1:0] tx, input logic [CSW-1:0] sel, input logic [1:0] mode);
    tx_data = tx;
    cs_sel  = sel;
    cpol    = mode[1];
    cpha    = mode[0];
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic waitDone();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 4 * LATENCY);
    if (!done) checkOutput("done_timeout", done, 1'b1);
  endtask

  // Monitor: per-frame checks at busy rise and at done; also plays the slave.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_busy = 1'b0;
      prev_sclk = 1'b0;
      prev_done = 1'b0;
      prev_cs_n = '1;
      rises     = 0;
    end else begin
      if (busy && !prev_busy) begin
        rises = 0;
        if (sb.size() > 0) begin
          checkOutput("cs_gap", prev_cs_n, CS_IDLE);
          checkOutput("sclk_setup", sclk, sb[0].pol);
          checkOutput("cs_n_active", cs_n, sb[0].cs);
          checkOutput("mosi_setup", mosi, sb[0].first_mosi);
        end else begin
          checkOutput("unexpected_busy", busy, 1'b0);
        end
      end
      if (busy && prev_busy && (sclk !== prev_sclk)) begin
        if (sclk) rises++;
        if (sclk !== sl_pol) begin
          if (sl_pha) begin
            sl_bit = sl_data[sl_idx];
            if (sl_idx > 0) sl_idx--;
          end
        end else if (!sl_pha && sl_idx > 0) begin
          sl_idx--;
          sl_bit = sl_data[sl_idx];
        end
      end
      if (prev_done) checkOutput("done_width", done, 1'b0);
      if (done) begin
        done_seen++;
        if (sb.size() > 0) begin
          mon_e = sb.pop_front();
          checkOutput("rx_data", rx_data, mon_e.rx);
          checkOutput("latency", cyc - mon_e.start_cyc, LATENCY);
          checkOutput("sclk_rises", rises, DATA_W);
          checkOutput("busy_at_done", busy, 1'b0);
          checkOutput("cs_n_at_done", cs_n, CS_IDLE);
          checkOutput("mosi_idle", mosi, 1'b0);
        end else begin
          checkOutput("spurious_done", done, 1'b0);
        end
      end
      prev_busy = busy;
      prev_sclk = sclk;
      prev_done = done;
      prev_cs_n = cs_n;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ds;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_rx", rx_data, '0);
    checkOutput("rst_sclk", sclk, 1'b0);
    checkOutput("rst_mosi", mosi, 1'b0);
    checkOutput("rst_cs_n", cs_n, CS_IDLE);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(8'hA5, 3'd0, MODE0, 1'b0, 1'b1, 8'h00);
    waitDone();
    repeat (5) @(negedge clk);
    checkOutput("rx_hold", rx_data, 8'hA5);

    applyStimulus(8'h5A, 3'd2, MODE3, 1'b0, 1'b0, 8'h3C);
    waitDone();
    repeat (3) @(negedge clk);
    checkOutput("sclk_idle_high", sclk, 1'b1);

    applyStimulus(8'h0F, 3'd1, MODE1, 1'b0, 1'b0, 8'h96);
    waitDone();
    @(negedge clk);
    applyStimulus(8'hF0, 3'd4, MODE2, 1'b0, 1'b0, 8'h69);
    waitDone();
    @(negedge clk);

    applyStimulus(8'hC3, 3'd5, MODE0, 1'b0, 1'b1, 8'h00);
    waitDone();
    @(negedge clk);

    applyStimulus(8'h81, 3'd1, MODE0, 1'b0, 1'b1, 8'h00);
    repeat (20) @(negedge clk);
    pulseStart(8'hFF, 3'd3, MODE3);
    @(negedge clk);
    checkOutput("cs_n_hold", cs_n, 5'b11101);
    waitDone();
    applyStimulus(8'h7E, 3'd4, MODE1, 1'b0, 1'b1, 8'h00);
    waitDone();
    @(negedge clk);

    applyStimulus(8'hF0, 3'd0, MODE3, 1'b0, 1'b1, 8'h00);
    repeat (30) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_done", done, 1'b0);
    checkOutput("abort_rx", rx_data, '0);
    checkOutput("abort_sclk", sclk, 1'b0);
    checkOutput("abort_mosi", mosi, 1'b0);
    checkOutput("abort_cs_n", cs_n, CS_IDLE);
    sb.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ds = done_seen;
    repeat (LATENCY + 10) @(negedge clk);
    checkOutput("no_done_after_abort", done_seen - ds, 0);
    checkOutput("sclk_after_reset", sclk, 1'b0);

    applyStimulus(8'h5A, 3'd0, MODE0, 1'b0, 1'b1, 8'h00);
    waitDone();
    @(negedge clk);

`ifdef SPI_MASTER_LSB_FIRST_EN
    applyStimulus(8'h01, 3'd0, MODE0, 1'b1, 1'b1, 8'h00);
    waitDone();
    @(negedge clk);
    applyStimulus(8'hB4, 3'd3, MODE1, 1'b1, 1'b1, 8'h00);
    waitDone();
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
